// File: rtl/fifo_tx_arb_pkg.sv
// Shared types and constants for the FIFO-to-UART TX arbiter.
package fifo_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2,
    LOAD    = 2'd3
  } state_t;

  // Last LOAD cycle count before a stuck transfer is abandoned.
  localparam logic [5:0] TIMEOUT_MAX = 6'h3F;

endpackage

// File: rtl/fifo_tx_arbiter_rr_arbiter.sv
// Combinational round-robin selector: first requester above last_grant, with wrap.
module rr_arbiter
  import fifo_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_FIFOS = 4,
  parameter int unsigned CW        = $clog2(NUM_FIFOS)
) (
  input  logic [NUM_FIFOS-1:0] req,
  input  logic [CW-1:0]        last_grant,
  output logic [CW-1:0]        grant,
  output logic                 grant_valid
);

  logic [CW-1:0] w_idx;

  // Scan upward from last_grant+1; the first requester found wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    w_idx       = '0;
    for (int unsigned i = 1; i <= NUM_FIFOS; i++) begin
      w_idx = CW'((32'(last_grant) + i) % NUM_FIFOS);
      if (!grant_valid && req[w_idx]) begin
        grant       = w_idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_tx_arbiter.sv
// Shares one UART transmitter among several channel FIFOs, round-robin,
// one word per grant, with a 64-cycle load timeout.
module fifo_tx_arbiter
  import fifo_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_FIFOS = 4,
  parameter int unsigned DATA_W    = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_FIFOS-1:0]          fifo_empty,
  input  logic [NUM_FIFOS*DATA_W-1:0]   fifo_data,
  input  logic [NUM_FIFOS-1:0]          chan_en,
  input  logic                          tx_busy,
  output logic [NUM_FIFOS-1:0]          read_fifo_n,
  output logic [DATA_W-1:0]             tx_data,
  output logic                          ld_tx_data,
  output logic [$clog2(NUM_FIFOS)-1:0]  active_chan,
  output logic                          timeout_err
);

  localparam int unsigned CW = $clog2(NUM_FIFOS);

  state_t                r_state;
  logic [CW-1:0]         r_grant;
  logic [CW-1:0]         r_last_grant;
  logic [5:0]            r_count;
  logic [NUM_FIFOS-1:0]  r_read_fifo_n;
  logic [DATA_W-1:0]     r_tx_data;
  logic                  r_ld_tx_data;
  logic [CW-1:0]         r_active_chan;
  logic                  r_timeout_err;

  logic [NUM_FIFOS-1:0]  w_req;
  logic [CW-1:0]         w_grant;
  logic                  w_grant_valid;

  // Channels that have data and are allowed to be serviced.
  always_comb begin
    w_req = ~fifo_empty & chan_en;
  end

  rr_arbiter #(
    .NUM_FIFOS (NUM_FIFOS),
    .CW        (CW)
  ) u_rr (
    .req         (w_req),
    .last_grant  (r_last_grant),
    .grant       (w_grant),
    .grant_valid (w_grant_valid)
  );

  // Transfer sequencer; every output is a register set one cycle ahead of its state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_last_grant  <= CW'(NUM_FIFOS - 1);
      r_count       <= '0;
      r_read_fifo_n <= '1;
      r_tx_data     <= '0;
      r_ld_tx_data  <= 1'b0;
      r_active_chan <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!tx_busy && w_grant_valid) begin
            r_grant       <= w_grant;
            r_active_chan <= w_grant;
            r_read_fifo_n <= ~(NUM_FIFOS'(1) << w_grant);
            r_state       <= READ;
          end
        end
        READ: begin
          r_read_fifo_n <= '1;
          r_state       <= CAPTURE;
        end
        CAPTURE: begin
          r_tx_data    <= fifo_data[r_grant*DATA_W +: DATA_W];
          r_ld_tx_data <= 1'b1;
          r_count      <= '0;
          r_state      <= LOAD;
        end
        LOAD: begin
          if (tx_busy || r_count == TIMEOUT_MAX) begin
            r_ld_tx_data  <= 1'b0;
            r_last_grant  <= r_grant;
            r_timeout_err <= ~tx_busy;
            r_state       <= IDLE;
          end else begin
            r_count <= r_count + 6'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign read_fifo_n = r_read_fifo_n;
  assign tx_data     = r_tx_data;
  assign ld_tx_data  = r_ld_tx_data;
  assign active_chan = r_active_chan;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_fifo_tx_arbiter.sv
// Self-checking bench for fifo_tx_arbiter (4 channels, 8-bit data).
module tb_fifo_tx_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  fifo_empty;
  logic [31:0] fifo_data;
  logic [3:0]  chan_en;
  logic        tx_busy;
  logic [3:0]  read_fifo_n;
  logic [7:0]  tx_data;
  logic        ld_tx_data;
  logic [1:0]  active_chan;
  logic        timeout_err;

  fifo_tx_arbiter #(
    .NUM_FIFOS (4),
    .DATA_W    (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .chan_en     (chan_en),
    .tx_busy     (tx_busy),
    .read_fifo_n (read_fifo_n),
    .tx_data     (tx_data),
    .ld_tx_data  (ld_tx_data),
    .active_chan (active_chan),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int rd_q[$];

  // Reference model: a transfer is tracked by its age and number of load cycles.
  logic [3:0] e_rd;
  logic       e_ld;
  logic [7:0] e_tx;
  logic [1:0] e_ac;
  logic       e_to;
  bit         m_act;
  int         m_age;
  int         m_chan;
  int         m_last;
  int         m_loads;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int last);
    logic [1:0] c;
    for (int k = 1; k <= 4; k++) begin
      c = 2'((last + k) % 4);
      if (r[c]) return int'(c);
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_act = 0; m_age = 0; m_chan = 0; m_last = 3; m_loads = 0;
    e_rd = 4'hF; e_ld = 1'b0; e_tx = 8'h00; e_ac = 2'd0; e_to = 1'b0;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_step();
    logic [3:0] req;
    req  = ~fifo_empty & chan_en;
    e_to = 1'b0;
    if (!m_act) begin
      if (!tx_busy && req != 4'h0) begin
        m_chan = rr_pick(req, m_last);
        m_act  = 1;
        m_age  = 1;
        e_rd   = ~(4'b0001 << m_chan);
        e_ac   = 2'(m_chan);
      end
    end else if (m_age == 1) begin
      e_rd  = 4'hF;
      m_age = 2;
    end else if (m_age == 2) begin
      e_tx    = fifo_data[m_chan*8 +: 8];
      e_ld    = 1'b1;
      m_age   = 3;
      m_loads = 0;
    end else begin
      m_loads++;
      if (tx_busy || m_loads == 64) begin
        e_ld   = 1'b0;
        m_act  = 0;
        m_last = m_chan;
        e_to   = !tx_busy;
      end
    end
  endtask

  task automatic check_model();
    chk("read_fifo_n", 32'(read_fifo_n), 32'(e_rd));
    chk("ld_tx_data",  32'(ld_tx_data),  32'(e_ld));
    chk("tx_data",     32'(tx_data),     32'(e_tx));
    chk("active_chan", 32'(active_chan), 32'(e_ac));
    chk("timeout_err", 32'(timeout_err), 32'(e_to));
  endtask

  // Called at a falling edge: drive inputs, step model, advance one cycle, observe.
  task automatic step(input logic [3:0] e, input logic [3:0] en, input logic b);
    fifo_empty = e;
    chan_en    = en;
    tx_busy    = b;
    model_step();
    @(posedge clk);
    @(negedge clk);
    if ($countones(~read_fifo_n) > 1) chk("one_read_low", 32'(read_fifo_n), 32'(e_rd));
    for (int i = 0; i < 4; i++) begin
      if (!read_fifo_n[i]) begin
        rd_q.push_back(i);
        chk("active_chan_at_read", 32'(active_chan), 32'(i));
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    rd_q.delete();
  endtask

  // Service channels with tx_busy raised on the second observed load cycle.
  task automatic run_pulsed(input logic [3:0] e, input logic [3:0] en,
                            input int budget, input int stop_reads);
    int ld_run;
    ld_run = 0;
    for (int c = 0; c < budget; c++) begin
      step(e, en, ld_run == 2);
      check_model();
      ld_run = ld_tx_data ? ld_run + 1 : 0;
      if (stop_reads > 0 && rd_q.size() >= stop_reads) break;
    end
  endtask

  typedef struct {
    logic [3:0] e;
    logic [3:0] en;
    logic       b;
    logic [3:0] rd;
    logic       ld;
    logic [7:0] tx;
    logic [1:0] ac;
    logic       to;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int ld_tot;
    int to_cnt;
    int cnt0;
    int cnt1;

    vecs[0] = '{e: 4'b1011, en: 4'hF, b: 1'b0, rd: 4'b1011, ld: 1'b0, tx: 8'h00, ac: 2'd2, to: 1'b0};
    vecs[1] = '{e: 4'b1111, en: 4'hF, b: 1'b0, rd: 4'b1111, ld: 1'b0, tx: 8'h00, ac: 2'd2, to: 1'b0};
    vecs[2] = '{e: 4'b1111, en: 4'hF, b: 1'b0, rd: 4'b1111, ld: 1'b1, tx: 8'hA5, ac: 2'd2, to: 1'b0};
    vecs[3] = '{e: 4'b1111, en: 4'hF, b: 1'b0, rd: 4'b1111, ld: 1'b1, tx: 8'hA5, ac: 2'd2, to: 1'b0};
    vecs[4] = '{e: 4'b1111, en: 4'hF, b: 1'b1, rd: 4'b1111, ld: 1'b0, tx: 8'hA5, ac: 2'd2, to: 1'b0};
    vecs[5] = '{e: 4'b1111, en: 4'hF, b: 1'b0, rd: 4'b1111, ld: 1'b0, tx: 8'hA5, ac: 2'd2, to: 1'b0};

    reset_n    = 1'b0;
    fifo_empty = 4'hF;
    chan_en    = 4'hF;
    fifo_data  = 32'h0;
    tx_busy    = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset values, then 100 idle cycles with every FIFO empty.
    do_reset();
    check_model();
    for (int c = 0; c < 100; c++) begin
      step(4'hF, 4'hF, 1'b0);
      check_model();
    end
    chk("idle_no_reads", 32'(rd_q.size()), 32'd0);

    // Single channel 2 transfer, table driven; data bus empties after the grant.
    do_reset();
    fifo_data = 32'h00A5_0000;
    for (int v = 0; v < 6; v++) begin
      step(vecs[v].e, vecs[v].en, vecs[v].b);
      chk("vec_read_fifo_n", 32'(read_fifo_n), 32'(vecs[v].rd));
      chk("vec_ld_tx_data",  32'(ld_tx_data),  32'(vecs[v].ld));
      chk("vec_tx_data",     32'(tx_data),     32'(vecs[v].tx));
      chk("vec_active_chan", 32'(active_chan), 32'(vecs[v].ac));
      chk("vec_timeout_err", 32'(timeout_err), 32'(vecs[v].to));
    end

    // Round-robin order with all four channels requesting.
    do_reset();
    fifo_data = 32'h4433_2211;
    run_pulsed(4'h0, 4'hF, 80, 5);
    chk("rr_read_count", 32'(rd_q.size()), 32'd5);
    for (int k = 0; k < 5 && k < rd_q.size(); k++)
      chk("rr_order", 32'(rd_q[k]), 32'(k % 4));

    // Load timeout: tx_busy never rises.
    do_reset();
    ld_tot = 0;
    to_cnt = 0;
    for (int c = 0; c < 100 && rd_q.size() < 2; c++) begin
      step(4'h0, 4'hF, 1'b0);
      check_model();
      if (ld_tx_data)  ld_tot++;
      if (timeout_err) to_cnt++;
    end
    chk("timeout_ld_cycles", 32'(ld_tot), 32'd64);
    chk("timeout_pulses",    32'(to_cnt), 32'd1);
    chk("timeout_reads",     32'(rd_q.size()), 32'd2);
    if (rd_q.size() >= 2) begin
      chk("timeout_first_chan", 32'(rd_q[0]), 32'd0);
      chk("timeout_next_chan",  32'(rd_q[1]), 32'd1);
    end

    // Disabled channel 1 is never serviced.
    do_reset();
    run_pulsed(4'b1100, 4'b1101, 200, 0);
    cnt0 = 0;
    cnt1 = 0;
    foreach (rd_q[k]) begin
      if (rd_q[k] == 0) cnt0++;
      if (rd_q[k] == 1) cnt1++;
    end
    chk("disabled_ch1_reads", 32'(cnt1), 32'd0);
    chk("enabled_ch0_repeat", 32'(cnt0 >= 5), 32'd1);

    // Asynchronous reset in the middle of a load.
    do_reset();
    for (int c = 0; c < 10 && !ld_tx_data; c++) begin
      step(4'h0, 4'hF, 1'b0);
      check_model();
    end
    chk("reached_load", 32'(ld_tx_data), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_ld_drop",   32'(ld_tx_data),  32'd0);
    chk("rst_rd_high",   32'(read_fifo_n), 32'hF);
    chk("rst_tx_data",   32'(tx_data),     32'd0);
    chk("rst_act_chan",  32'(active_chan), 32'd0);
    @(negedge clk);
    do_reset();
    step(4'h0, 4'hF, 1'b0);
    check_model();
    chk("post_rst_read", 32'(rd_q.size()), 32'd1);
    if (rd_q.size() >= 1) chk("post_rst_chan0", 32'(rd_q[0]), 32'd0);

    // Randomised traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      fifo_data = $urandom();
      step(4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF,
           $urandom_range(0, 7) == 0);
      check_model();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
